// File: rtl/pcpu_mem_loader.sv
// Instruction/data memory for pcpu with a streaming loader front end.
// The loader owns both banks until a GO header hands control to the CPU.
module pcpu_mem_loader #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned IDEPTH = 256,
  parameter int unsigned DDEPTH = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              reload,
  output logic              cpu_enable,
  output logic              cpu_start,
  output logic              load_busy,
  output logic              ovf,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_datain,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_dataout,
  output logic [DATA_W-1:0] d_datain
);

  localparam int unsigned IW = (IDEPTH > 1) ? $clog2(IDEPTH) : 1;
  localparam int unsigned DW = (DDEPTH > 1) ? $clog2(DDEPTH) : 1;

  typedef enum logic [2:0] {StHdr, StCnt, StData, StStart, StRun} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   remaining_q, remaining_d;
  logic                bank_q, bank_d;
  logic                ovf_q, ovf_d;

  logic [DATA_W-1:0]   iram [IDEPTH];
  logic [DATA_W-1:0]   dram [DDEPTH];

  logic                accept;
  logic                hdr_bank, hdr_go;
  logic [31:0]         depth_sel, ld_idx;
  logic                ld_wrap;
  logic [IW-1:0]       i_idx;
  logic [DW-1:0]       d_idx;
  logic                cpu_we, iram_we, dram_we;
  logic [DW-1:0]       dram_widx;
  logic [DATA_W-1:0]   dram_wdata;

  assign accept   = ld_valid && ld_ready;
  assign hdr_bank = ld_data[DATA_W-1];
  assign hdr_go   = ld_data[DATA_W-2];

  // Load pointer is reduced modulo the selected bank so a header address
  // beyond the depth aliases like a CPU access would.
  always_comb begin
    depth_sel = bank_q ? DDEPTH : IDEPTH;
    ld_idx    = 32'(addr_q) % depth_sel;
    ld_wrap   = (ld_idx == depth_sel - 32'd1);
  end

  assign i_idx    = IW'(32'(i_addr) % IDEPTH);
  assign d_idx    = DW'(32'(d_addr) % DDEPTH);
  assign i_datain = iram[i_idx];
  assign d_datain = dram[d_idx];

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= StHdr;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHdr:   if (accept) state_d = hdr_go ? StStart : StCnt;
      StCnt:   if (accept) state_d = (ld_data == '0) ? StHdr : StData;
      StData:  if (accept && remaining_q == DATA_W'(1)) state_d = StHdr;
      StStart: state_d = StRun;
      StRun:   if (reload) state_d = StHdr;
      default: state_d = StHdr;
    endcase
  end

  // Moore outputs
  always_comb begin
    ld_ready   = 1'b0;
    cpu_enable = 1'b0;
    cpu_start  = 1'b0;
    load_busy  = 1'b0;
    unique case (state_q)
      StHdr, StCnt, StData: begin
        ld_ready  = 1'b1;
        load_busy = 1'b1;
      end
      StStart: begin
        cpu_enable = 1'b1;
        cpu_start  = 1'b1;
      end
      StRun:   cpu_enable = 1'b1;
      default: ;
    endcase
  end

  assign ovf = ovf_q;

  // Loader datapath
  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;
    bank_d      = bank_q;
    ovf_d       = ovf_q;
    unique case (state_q)
      StHdr: begin
        if (accept && !hdr_go) begin
          bank_d = hdr_bank;
          addr_d = ld_data[ADDR_W-1:0];
        end
      end
      StCnt:   if (accept) remaining_d = ld_data;
      StData: begin
        if (accept) begin
          addr_d      = ld_wrap ? '0 : ADDR_W'(ld_idx + 32'd1);
          remaining_d = remaining_q - DATA_W'(1);
          if (ld_wrap) ovf_d = 1'b1;
        end
      end
      StRun:   if (reload) ovf_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q      <= '0;
      remaining_q <= '0;
      bank_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      bank_q      <= bank_d;
      ovf_q       <= ovf_d;
    end
  end

  // The CPU only gets the data write port in RUN; loader and CPU never overlap.
  always_comb begin
    cpu_we     = (state_q == StRun) && d_we;
    iram_we    = (state_q == StData) && accept && !bank_q;
    dram_we    = ((state_q == StData) && accept && bank_q) || cpu_we;
    dram_widx  = cpu_we ? d_idx : DW'(ld_idx);
    dram_wdata = cpu_we ? d_dataout : ld_data;
  end

  always_ff @(posedge clock) begin
    if (!reset && iram_we) iram[IW'(ld_idx)] <= ld_data;
  end

  always_ff @(posedge clock) begin
    if (!reset && dram_we) dram[dram_widx] <= dram_wdata;
  end

endmodule

// File: tb/tb_pcpu_mem_loader.sv
// Directed, table-driven bench for pcpu_mem_loader with default parameters.
module tb_pcpu_mem_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        ld_valid;
  logic        ld_ready;
  logic [15:0] ld_data;
  logic        reload;
  logic        cpu_enable;
  logic        cpu_start;
  logic        load_busy;
  logic        ovf;
  logic [7:0]  i_addr;
  logic [15:0] i_datain;
  logic [7:0]  d_addr;
  logic        d_we;
  logic [15:0] d_dataout;
  logic [15:0] d_datain;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  pcpu_mem_loader dut (
    .clock      (clock),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .reload     (reload),
    .cpu_enable (cpu_enable),
    .cpu_start  (cpu_start),
    .load_busy  (load_busy),
    .ovf        (ovf),
    .i_addr     (i_addr),
    .i_datain   (i_datain),
    .d_addr     (d_addr),
    .d_we       (d_we),
    .d_dataout  (d_dataout),
    .d_datain   (d_datain)
  );

  // Flag order: {ld_ready, cpu_enable, cpu_start, load_busy, ovf}
  localparam logic [4:0] FLoad   = 5'b10010;
  localparam logic [4:0] FLoadO  = 5'b10011;
  localparam logic [4:0] FStart  = 5'b01100;
  localparam logic [4:0] FStartO = 5'b01101;
  localparam logic [4:0] FRun    = 5'b01000;
  localparam logic [4:0] FRunO   = 5'b01001;

  // Example program words: LOAD gr1, LOAD gr2, NOP
  localparam logic [15:0] InsLoad1 = 16'h1100;
  localparam logic [15:0] InsLoad2 = 16'h1201;
  localparam logic [15:0] InsNop   = 16'h0000;

  typedef struct {
    bit          rst;
    bit          vld;
    logic [15:0] dat;
    bit          rld;
    bit          we;
    logic [7:0]  da;
    logic [15:0] dout;
    logic [4:0]  flags;
    bit          ci;
    logic [7:0]  ia;
    logic [15:0] ei;
    bit          cd;
    logic [15:0] ed;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input bit rst, input bit vld, input logic [15:0] dat,
                             input bit rld, input bit we, input logic [7:0] da,
                             input logic [15:0] dout, input logic [4:0] flags,
                             input bit ci, input logic [7:0] ia, input logic [15:0] ei,
                             input bit cd, input logic [15:0] ed);
    vec_t r;
    r.rst = rst; r.vld = vld; r.dat = dat; r.rld = rld; r.we = we; r.da = da;
    r.dout = dout; r.flags = flags; r.ci = ci; r.ia = ia; r.ei = ei; r.cd = cd; r.ed = ed;
    return r;
  endfunction

  function automatic vec_t ld(input logic [15:0] dat, input logic [4:0] flags);
    return v(0, 1, dat, 0, 0, 8'h00, 16'h0, flags, 0, 8'h00, 16'h0, 0, 16'h0);
  endfunction

  function automatic vec_t idle(input logic [4:0] flags);
    return v(0, 0, 16'h0, 0, 0, 8'h00, 16'h0, flags, 0, 8'h00, 16'h0, 0, 16'h0);
  endfunction

  function automatic vec_t rdi(input logic [7:0] ia, input logic [15:0] ei,
                               input logic [4:0] flags);
    return v(0, 0, 16'h0, 0, 0, 8'h00, 16'h0, flags, 1, ia, ei, 0, 16'h0);
  endfunction

  function automatic vec_t rdd(input logic [7:0] da, input logic [15:0] ed,
                               input logic [4:0] flags);
    return v(0, 0, 16'h0, 0, 0, da, 16'h0, flags, 0, 8'h00, 16'h0, 1, ed);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] flags_now();
    return {ld_ready, cpu_enable, cpu_start, load_busy, ovf};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1; ld_valid = 0; ld_data = '0; reload = 0;
    i_addr = '0; d_addr = '0; d_we = 0; d_dataout = '0;

    // IRAM program load
    tbl.push_back(ld(16'h0000, FLoad));
    tbl.push_back(ld(16'h0003, FLoad));
    tbl.push_back(ld(InsLoad1, FLoad));
    tbl.push_back(ld(InsLoad2, FLoad));
    tbl.push_back(ld(InsNop, FLoad));
    tbl.push_back(rdi(8'h00, InsLoad1, FLoad));
    tbl.push_back(rdi(8'h01, InsLoad2, FLoad));
    tbl.push_back(rdi(8'h02, InsNop, FLoad));
    // DRAM load
    tbl.push_back(ld(16'h8000, FLoad));
    tbl.push_back(ld(16'h0003, FLoad));
    tbl.push_back(ld(16'h00AB, FLoad));
    tbl.push_back(ld(16'h3C00, FLoad));
    tbl.push_back(ld(16'h0000, FLoad));
    tbl.push_back(rdd(8'h00, 16'h00AB, FLoad));
    tbl.push_back(rdd(8'h01, 16'h3C00, FLoad));
    // GO with CPU writes attempted in HDR and START: both ignored
    tbl.push_back(v(0, 1, 16'h4000, 0, 1, 8'h02, 16'hDEAD, FStart, 0, 8'h0, 16'h0, 1, 16'h0000));
    tbl.push_back(v(0, 1, 16'h1234, 0, 1, 8'h02, 16'hDEAD, FRun, 0, 8'h0, 16'h0, 1, 16'h0000));
    // RUN write
    tbl.push_back(v(0, 0, 16'h0, 0, 1, 8'h02, 16'h3CAB, FRun, 0, 8'h0, 16'h0, 1, 16'h3CAB));
    tbl.push_back(v(0, 0, 16'h0, 1, 0, 8'h00, 16'h0, FLoad, 0, 8'h0, 16'h0, 0, 16'h0));
    // First cycle after reload: write ignored; header for wrap load
    tbl.push_back(v(0, 1, 16'h00FE, 0, 1, 8'h02, 16'hBEEF, FLoad, 0, 8'h0, 16'h0, 1, 16'h3CAB));
    tbl.push_back(ld(16'h0003, FLoad));
    tbl.push_back(v(0, 1, 16'hA001, 0, 1, 8'h02, 16'h1111, FLoad, 0, 8'h0, 16'h0, 1, 16'h3CAB));
    tbl.push_back(ld(16'hA002, FLoadO));
    tbl.push_back(ld(16'hA003, FLoadO));
    tbl.push_back(v(0, 0, 16'h0, 0, 0, 8'h02, 16'h0, FLoadO, 1, 8'hFE, 16'hA001, 1, 16'h3CAB));
    tbl.push_back(rdi(8'hFF, 16'hA002, FLoadO));
    tbl.push_back(rdi(8'h00, 16'hA003, FLoadO));
    // N=0 writes nothing
    tbl.push_back(ld(16'h0001, FLoadO));
    tbl.push_back(ld(16'h0000, FLoadO));
    tbl.push_back(rdi(8'h01, InsLoad2, FLoadO));
    // reload outside RUN ignored
    tbl.push_back(v(0, 0, 16'h0, 1, 0, 8'h00, 16'h0, FLoadO, 0, 8'h0, 16'h0, 0, 16'h0));
    tbl.push_back(ld(16'h4000, FStartO));
    tbl.push_back(idle(FRunO));
    tbl.push_back(v(0, 0, 16'h0, 1, 0, 8'h00, 16'h0, FLoad, 0, 8'h0, 16'h0, 0, 16'h0));
    tbl.push_back(ld(16'h4000, FStart));
    tbl.push_back(idle(FRun));
    tbl.push_back(v(0, 0, 16'h0, 1, 0, 8'h00, 16'h0, FLoad, 0, 8'h0, 16'h0, 0, 16'h0));
    // Reset mid-DATA after one of three words
    tbl.push_back(ld(16'h8020, FLoad));
    tbl.push_back(ld(16'h0003, FLoad));
    tbl.push_back(ld(16'h7777, FLoad));
    tbl.push_back(v(1, 1, 16'h8888, 0, 0, 8'h20, 16'h0, FLoad, 0, 8'h0, 16'h0, 1, 16'h7777));
    tbl.push_back(ld(16'h4000, FStart));
    tbl.push_back(idle(FRun));
    // Reset dominates reload
    tbl.push_back(v(1, 0, 16'h0, 1, 0, 8'h00, 16'h0, FLoad, 0, 8'h0, 16'h0, 0, 16'h0));

    step();
    step();
    reset = 0;
    chk("reset flags", 32'(flags_now()), 32'(FLoad));

    foreach (tbl[i]) begin
      reset = tbl[i].rst; ld_valid = tbl[i].vld; ld_data = tbl[i].dat;
      reload = tbl[i].rld; d_we = tbl[i].we; d_addr = tbl[i].da; d_dataout = tbl[i].dout;
      i_addr = tbl[i].ia;
      step();
      chk($sformatf("vec%0d flags", i), 32'(flags_now()), 32'(tbl[i].flags));
      if (tbl[i].ci) chk($sformatf("vec%0d i_datain", i), 32'(i_datain), 32'(tbl[i].ei));
      if (tbl[i].cd) chk($sformatf("vec%0d d_datain", i), 32'(d_datain), 32'(tbl[i].ed));
    end
    reset = 0; reload = 0; d_we = 0; ld_valid = 0;

    // Sustained back-to-back DRAM burst wrapping past the top of the bank
    ld_valid = 1;
    ld_data  = 16'h80FD;
    step();
    ld_data  = 16'h0004;
    step();
    for (int k = 0; k < 4; k++) begin
      ld_data = 16'hC000 + 16'(k);
      chk($sformatf("burst%0d ready", k), 32'(ld_ready), 32'd1);
      step();
      chk($sformatf("burst%0d ovf", k), 32'(ovf), (k >= 2) ? 32'd1 : 32'd0);
    end
    ld_valid = 0;
    for (int k = 0; k < 4; k++) begin
      d_addr = 8'hFD + 8'(k);
      #1;
      chk($sformatf("burst rd%0d", k), 32'(d_datain), 32'(16'hC000 + 16'(k)));
    end
    i_addr = 8'h00;
    #1;
    chk("iram untouched", 32'(i_datain), 32'h0000A003);
    chk("burst end flags", 32'(flags_now()), 32'(FLoadO));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
